// File: rtl/pipelined_normalizer_pkg.sv
// pipelined_normalizer_pkg: default widths and stage payload types for the normalizer pipeline
package pipelined_normalizer_pkg;
  localparam int SUM_W_DEF = 20;
  localparam int MAN_W_DEF = 11;
  localparam int EXP_W_DEF = 6;
  localparam int P_W = $clog2(SUM_W_DEF + 1);
  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic [SUM_W_DEF-1:0] mag;
    logic [EXP_W_DEF-1:0] exp;
  } s1_t;
  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic [P_W-1:0]       p;
    logic [MAN_W_DEF-1:0] mant;
    logic                 guard;
    logic                 sticky;
    logic [EXP_W_DEF-1:0] exp;
  } s2_t;
endpackage

// File: rtl/pipelined_normalizer_lod.sv
// leading_one_detector: 1-based position of the most significant set bit, 0 when the input is zero
module leading_one_detector #(
  parameter int W = 20,
  localparam int PW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [PW-1:0] pos
);
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) pos = d[i] ? PW'(i + 1) : pos;
  end
endmodule

// File: rtl/pipelined_normalizer.sv
// pipelined_normalizer: three-stage sign/magnitude, normalize-shift and RNE-round pipeline with backpressure
module pipelined_normalizer
  import pipelined_normalizer_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] signed_sum,
  input  logic [EXP_W-1:0] exp_max,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [MAN_W-1:0] norm_sum,
  output logic [EXP_W:0]   exp_final,
  output logic             zero,
  output logic             exp_ovf
);
  localparam int XW = EXP_W + 2;
  localparam logic [P_W-1:0] MAN_P = P_W'(MAN_W);
  logic adv;
  logic s1_v_d, s1_v_q, s2_v_d, s2_v_q, out_valid_d, out_valid_q;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic [P_W-1:0] p, sh_r, sh_l;
  logic [SUM_W-1:0] low_mask;
  logic inc, carry;
  logic [MAN_W:0] rnd;
  logic [XW-1:0] ex;
  logic sign_d, sign_q, zero_d, zero_q, ovf_d, ovf_q;
  logic [MAN_W-1:0] norm_d, norm_q;
  logic [EXP_W:0] expf_d, expf_q;

  assign adv = out_ready | ~out_valid_q;
  assign in_ready = adv;

  leading_one_detector #(.W(SUM_W)) u_lod (.d(s1_q.mag), .pos(p));

  always_comb begin
    s1_v_d = adv ? in_valid : s1_v_q;
    s1_d = s1_q;
    if (adv) begin
      s1_d.sign = signed_sum[SUM_W-1];
      s1_d.zero = ~|signed_sum;
      s1_d.mag = signed_sum[SUM_W-1] ? -signed_sum : signed_sum;
      s1_d.exp = exp_max;
    end
  end

  always_comb begin
    sh_r = p > MAN_P ? p - MAN_P : '0;
    sh_l = p > MAN_P ? '0 : MAN_P - p;
    low_mask = ~({SUM_W{1'b1}} << sh_r);
    s2_v_d = adv ? s1_v_q : s2_v_q;
    s2_d = s2_q;
    if (adv) begin
      s2_d.sign = s1_q.sign;
      s2_d.zero = s1_q.zero;
      s2_d.exp = s1_q.exp;
      s2_d.p = p;
      s2_d.mant = p > MAN_P ? MAN_W'(s1_q.mag >> sh_r) : s1_q.mag[MAN_W-1:0] << sh_l;
      s2_d.guard = |(s1_q.mag & low_mask & ~(low_mask >> 1));
      s2_d.sticky = |(s1_q.mag & (low_mask >> 1));
    end
  end

  always_comb begin
    inc = s2_q.guard & (s2_q.sticky | s2_q.mant[0]);
    rnd = {1'b0, s2_q.mant} + {{MAN_W{1'b0}}, inc};
    carry = rnd[MAN_W];
    ex = {{2{s2_q.exp[EXP_W-1]}}, s2_q.exp} + {{(XW-P_W){1'b0}}, s2_q.p} - XW'(MAN_W) + {{(XW-1){1'b0}}, carry};
    out_valid_d = adv ? s2_v_q : out_valid_q;
    sign_d = adv ? s2_q.sign : sign_q;
    zero_d = adv ? s2_q.zero : zero_q;
    norm_d = adv ? (s2_q.zero ? '0 : carry ? {1'b1, {(MAN_W-1){1'b0}}} : rnd[MAN_W-1:0]) : norm_q;
    expf_d = adv ? (s2_q.zero ? '0 : (ex[XW-1] ^ ex[XW-2]) ? {ex[XW-1], {EXP_W{~ex[XW-1]}}} : ex[EXP_W:0]) : expf_q;
    ovf_d = adv ? (~s2_q.zero & (ex[XW-1] ^ ex[XW-2])) : ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      norm_q <= '0;
      expf_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      out_valid_q <= out_valid_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      sign_q <= sign_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      norm_q <= norm_d;
      expf_q <= expf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sign = sign_q;
  assign zero = zero_q;
  assign exp_ovf = ovf_q;
  assign norm_sum = norm_q;
  assign exp_final = expf_q;
endmodule
